// File: rtl/riscv_lsu_mem_port.sv
// Load/store port between the core memory stage and a word-organised SRAM.
// Takes one byte/half/word request at a time, drives a word-aligned SRAM
// access with byte-lane enables and lane-replicated store data, extracts and
// extends load data from the registered SRAM read port, and returns exactly
// one response per request (with an error flag for misaligned/illegal/SRAM
// errors).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE. rsp_valid stays 1, with rsp_rdata and
// rsp_error stable, until the edge where rsp_ready is 1. mem_stall=1 freezes
// every mem_* output until the edge where it is 0.
module riscv_lsu_mem_port #(
    parameter int addr_w = 32,
    parameter int data_w = 32
) (
    input  logic              gclk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [addr_w-1:0] req_addr,
    input  logic [data_w-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [data_w-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [addr_w-1:0] mem_addr,
    output logic [data_w-1:0] mem_wdata,
    output logic [3:0]        mem_b_en,
    output logic              mem_w_en,
    input  logic [data_w-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_error,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    state_e              state_q, state_d;

    logic [addr_w-1:0]   mem_addr_q;
    logic [data_w-1:0]   mem_wdata_q;
    logic [3:0]          mem_b_en_q;
    logic                mem_w_en_q;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic                write_q;
    logic                err_q;
    logic [data_w-1:0]   rsp_rdata_q;
    logic                rsp_error_q;

    logic                req_bad;
    logic [3:0]          req_lanes;
    logic [data_w-1:0]   req_wdata_rep;
    logic [data_w-1:0]   rd_shifted;
    logic [data_w-1:0]   rd_ext;

    // Request decode: alignment/size check, lane enables, store-data replication
    always_comb begin
        req_bad       = 1'b0;
        req_lanes     = 4'b0000;
        req_wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                req_lanes     = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_bad       = req_addr[0];
                req_lanes     = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_bad       = (req_addr[1:0] != 2'b00);
                req_lanes     = 4'b1111;
                req_wdata_rep = req_wdata;
            end
            default: begin
                req_bad       = 1'b1;
            end
        endcase
    end

    // Load extraction: move the addressed lanes to the bottom, then extend
    always_comb begin
        rd_shifted = mem_rdata >> {off_q, 3'b000};
        rd_ext     = mem_rdata;
        case (size_q)
            2'b00:   rd_ext = signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                       : {24'h000000, rd_shifted[7:0]};
            2'b01:   rd_ext = signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                       : {16'h0000, rd_shifted[15:0]};
            default: rd_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge gclk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = req_bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!mem_stall) begin
                    state_d = write_q ? S_RESP : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        dbg_state = state_q;
    end

    // Datapath: memory-side registers, request context and response registers
    always_ff @(posedge gclk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_b_en_q  <= 4'b0000;
            mem_w_en_q  <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            // Rejected up front: the SRAM is never touched
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            mem_addr_q  <= {req_addr[addr_w-1:2], 2'b00};
                            mem_wdata_q <= req_wdata_rep;
                            mem_b_en_q  <= req_lanes;
                            mem_w_en_q  <= req_write;
                            off_q       <= req_addr[1:0];
                            size_q      <= req_size;
                            signed_q    <= req_signed;
                            write_q     <= req_write;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!mem_stall) begin
                        // SRAM takes the access on this edge; drop the enables
                        err_q      <= mem_error;
                        mem_b_en_q <= 4'b0000;
                        mem_w_en_q <= 1'b0;
                        if (write_q) begin
                            rsp_error_q <= mem_error;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    rsp_error_q <= err_q;
                    rsp_rdata_q <= err_q ? '0 : rd_ext;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b0;
                    end
                end
                default: begin
                    rsp_error_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_b_en  = mem_b_en_q;
    assign mem_w_en  = mem_w_en_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_riscv_lsu_mem_port.sv
// Bench for riscv_lsu_mem_port: byte-addressed reference memory, a simple
// registered-read SRAM attached to the mem_* port, directed steps followed by
// randomized requests.
module tb_riscv_lsu_mem_port;

    logic        gclk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_b_en;
    logic        mem_w_en;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_error;
    logic [1:0]  dbg_state;
    logic        err_inject;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  model_mem [0:255];
    logic [31:0] sram [0:63];

    riscv_lsu_mem_port #(.addr_w(32), .data_w(32)) dut (
        .gclk       (gclk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_b_en   (mem_b_en),
        .mem_w_en   (mem_w_en),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .mem_error  (mem_error),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    // SRAM: address-range error is combinational while an access is presented
    assign mem_error = err_inject & (|mem_b_en);

    // SRAM: registered read, byte-lane write, contents restored on reset
    always @(posedge gclk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
        end else if (mem_b_en != 4'b0000 && !mem_stall) begin
            if (mem_w_en) begin
                if (!mem_error) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_b_en[i]) sram[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr[7:2]];
            end
        end
    end

    task automatic model_init();
        for (int a = 0; a < 256; a++) begin
            logic [31:0] w;
            w = init_word(a / 4);
            model_mem[a] = w[8*(a%4) +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request from acceptance to response handshake
    task automatic do_req(input bit wr, input bit [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input bit err, input int hold,
                          output logic [31:0] rd_out);
        int          n;
        bit          bad;
        bit          merr;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_er;
        logic [3:0]  exp_lanes;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;
        int          lat;
        int          active;
        int          wen;
        int          bad_hold;

        n    = (sz == 2'b11) ? 4 : (1 << sz);
        bad  = (sz == 2'b11) || ((addr % n) != 0);
        merr = !bad && err;
        exp_lat  = bad ? 1 : ((wr ? 2 : 3) + stall);
        exp_addr = addr & ~32'h3;
        exp_lanes = 4'b0000;
        exp_wd    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_lanes[i]     = (i >= (addr % 4)) && (i < (addr % 4) + n);
            exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        exp_rd = 32'h0;
        exp_er = bad || merr;
        if (!exp_er && !wr) begin
            for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(model_mem[addr + i]) << (8*i));
            if (sg && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'd1 << (8*n)) - 1);
        end

        @(negedge gclk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        err_inject = err;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge gclk);
        #1 req_valid = 1'b0;

        lat = 0; active = 0; wen = 0; bad_hold = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge gclk);
            if (mem_b_en != 4'b0000) begin
                active++;
                if (mem_addr !== exp_addr || mem_b_en !== exp_lanes || (wr && mem_wdata !== exp_wd))
                    bad_hold++;
            end
            if (mem_w_en) wen++;
            if (rsp_valid) begin
                lat = c + 1;
                break;
            end
            mem_stall = (c < stall);
        end
        mem_stall  = 1'b0;
        err_inject = 1'b0;

        check("latency", 32'(lat), 32'(exp_lat));
        check("b_en_cycles", 32'(active), bad ? 32'd0 : 32'(stall + 1));
        check("w_en_cycles", 32'(wen), (!bad && wr) ? 32'(stall + 1) : 32'd0);
        if (!bad) check("mem_outputs", 32'(bad_hold), 32'd0);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_error", 32'(rsp_error), 32'(exp_er));
        rd_out = rsp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(negedge gclk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_error", 32'(rsp_error), 32'(exp_er));
        end
        rsp_ready = 1'b1;
        @(negedge gclk);
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
        check("post_rdata", rsp_rdata, 32'd0);
        check("post_error", 32'(rsp_error), 32'd0);

        if (!exp_er && wr)
            for (int i = 0; i < n; i++) model_mem[addr + i] = wd[8*i +: 8];
    endtask

    // Load aborted by reset while the read data is being captured
    task automatic reset_in_capture(input logic [31:0] addr);
        int seen;
        @(negedge gclk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = addr;
        @(posedge gclk);
        #1 req_valid = 1'b0;
        @(negedge gclk);
        check("rst_access_b_en", 32'(mem_b_en), 32'hF);
        @(negedge gclk);
        reset = 1'b1;
        @(negedge gclk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_b_en", 32'(mem_b_en), 32'd0);
        check("rst_w_en", 32'(mem_w_en), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge gclk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        check("rst_no_response", 32'(seen), 32'd0);
        model_init();
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0; mem_stall = 1'b0; err_inject = 1'b0;
        model_init();
        repeat (3) @(posedge gclk);
        @(negedge gclk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_mem_b_en", 32'(mem_b_en), 32'd0);
        check("reset_mem_w_en", 32'(mem_w_en), 32'd0);
        reset = 1'b0;

        // Word store then load
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, r);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, 0, r);
        check("lw_const", r, 32'hDEADBEEF);
        // Byte store into the top lane, signed and unsigned loads
        do_req(1, 2'b00, 0, 32'h13, 32'h000000A5, 0, 0, 0, r);
        do_req(0, 2'b00, 1, 32'h13, 32'h0, 0, 0, 0, r);
        check("lb_const", r, 32'hFFFFFFA5);
        do_req(0, 2'b00, 0, 32'h13, 32'h0, 0, 0, 0, r);
        check("lbu_const", r, 32'h000000A5);
        // Upper halfword store, signed load, word view
        do_req(1, 2'b01, 0, 32'h16, 32'h00008001, 0, 0, 0, r);
        do_req(0, 2'b01, 1, 32'h16, 32'h0, 0, 0, 0, r);
        check("lh_const", r, 32'hFFFF8001);
        do_req(0, 2'b10, 0, 32'h14, 32'h0, 0, 0, 0, r);
        check("lw_upper_half", {16'h0, r[31:16]}, 32'h00008001);
        // Misaligned and illegal size
        do_req(0, 2'b10, 0, 32'h11, 32'h0, 0, 0, 0, r);
        do_req(0, 2'b01, 1, 32'h13, 32'h0, 0, 0, 0, r);
        do_req(0, 2'b11, 0, 32'h20, 32'h0, 0, 0, 0, r);
        do_req(1, 2'b11, 0, 32'h24, 32'h12345678, 0, 0, 0, r);
        do_req(1, 2'b01, 0, 32'h25, 32'h12345678, 0, 0, 0, r);
        do_req(0, 2'b10, 0, 32'h24, 32'h0, 0, 0, 0, r);
        // Stall, SRAM error on load and store, held response
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 3, 0, 0, r);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 0, r);
        do_req(1, 2'b10, 0, 32'h18, 32'hCAFEF00D, 1, 1, 0, r);
        do_req(0, 2'b10, 0, 32'h18, 32'h0, 0, 0, 0, r);
        do_req(1, 2'b00, 0, 32'h31, 32'h0000007E, 2, 0, 0, r);
        do_req(0, 2'b00, 1, 32'h13, 32'h0, 0, 0, 5, r);
        // Reset while a load is in its capture cycle
        reset_in_capture(32'h10);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, 0, r);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            int          k;
            bit [1:0]    sz;
            logic [31:0] a;
            k  = $urandom_range(0, 9);
            sz = (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 2), ($urandom_range(0, 7) == 0), $urandom_range(0, 2), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
